i_mem_word_to_byte_ctrl: RTL and testbench

//  Ring-side front end for the byte-wide instruction memory (port b).
//  - Accepts one 32-bit word read/write request at a time over a valid/ready handshake.
//  - Serialises each request into four byte accesses on the memory port.
//  - Reassembles read bytes, which return one cycle after each read is issued.
//  - Returns one response per request. The core-side port (a) is untouched.

---
 rtl/i_mem_word_to_byte_ctrl.sv | 138 +++++++++++++
 tb/tb_i_mem_word_to_byte_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/i_mem_word_to_byte_ctrl.sv
// Ring-side port-b front end for the byte-wide instruction memory: serialises one 32-bit
// word request into four byte accesses and reassembles read data into a single response.
module i_mem_word_to_byte_ctrl #(
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [7:0]        mem_q
);

    typedef enum logic [1:0] {StIdle, StAccess, StDrain, StResp} state_e;

    state_e            state_q;
    logic [ADDR_W-3:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              wr_q;
    logic [1:0]        cnt_q;
    logic              cap_en_q;
    logic [1:0]        cap_lane_q;
    logic [31:0]       rbuf_q;

    // Source of the next byte access: the live request on the handshake, else the latched one.
    logic [ADDR_W-3:0] src_addr;
    logic [31:0]       src_data;
    logic [3:0]        src_be;
    logic              src_wr;
    logic [1:0]        src_cnt;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    assign req_ready = (state_q == StIdle);

    always_comb begin
        src_addr = addr_q;
        src_data = wdata_q;
        src_be   = be_q;
        src_wr   = wr_q;
        src_cnt  = cnt_q + 2'd1;
        if (state_q == StIdle) begin
            src_addr = req_addr[ADDR_W-1:2];
            src_data = req_data;
            src_be   = req_be;
            src_wr   = req_wr;
            src_cnt  = 2'd0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            cap_en_q    <= 1'b0;
            cap_lane_q  <= '0;
            rbuf_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
        end else begin
            // Read data returns one cycle after issue; the delayed lane steers it into the word.
            cap_en_q   <= mem_rden;
            cap_lane_q <= mem_address[1:0];
            if (cap_en_q) begin
                rbuf_q[{cap_lane_q, 3'b000} +: 8] <= mem_q;
            end
            rsp_valid <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q  <= src_addr;
                        wdata_q <= src_data;
                        be_q    <= src_be;
                        wr_q    <= src_wr;
                        cnt_q   <= 2'd0;
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (wr_q) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            state_q   <= StResp;
                        end else begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // Byte 3 arrives now; merge it directly into the response word.
                    rsp_valid <= 1'b1;
                    rsp_data  <= {mem_q, rbuf_q[23:0]};
                    state_q   <= StResp;
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            // Registered memory strobes: loaded for the byte about to be accessed, else idle.
            if ((state_q == StIdle && req_valid) || (state_q == StAccess && cnt_q != 2'd3)) begin
                mem_address <= {src_addr, src_cnt};
                mem_rden    <= !src_wr;
                mem_wren    <= src_wr && src_be[src_cnt];
                mem_data    <= src_wr ? src_data[{src_cnt, 3'b000} +: 8] : 8'h00;
            end else begin
                mem_address <= '0;
                mem_rden    <= 1'b0;
                mem_wren    <= 1'b0;
                mem_data    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_i_mem_word_to_byte_ctrl.sv
// Directed bench for i_mem_word_to_byte_ctrl with a byte-memory model and a response
// scoreboard.
module tb_i_mem_word_to_byte_ctrl;

    localparam int unsigned AW = 13;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_data;
    logic [3:0]    req_be;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_data;
    logic          mem_rden;
    logic          mem_wren;
    logic [7:0]    mem_q;

    always #5 clock = ~clock;

    i_mem_word_to_byte_ctrl #(.ADDR_W(AW)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    // Byte memory with registered read output; contents survive controller reset.
    logic [7:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem_q = 8'h00;
    end
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        if (mem_rden) mem_q <= mem[mem_address];
    end

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic wr, input logic [AW-1:0] addr, input logic [31:0] data,
                         input logic [3:0] be);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_data  = data;
        req_be    = be;
    endtask

    // Called at a negedge with a request already driven; returns at the negedge of the
    // first IDLE cycle after the response. With hold set, req_valid stays high carrying
    // the next request's fields.
    task automatic xfer(input logic [31:0] exp, input bit hold, input logic nwr,
                        input logic [AW-1:0] naddr);
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic [3:0]    b;
        logic [1:0]    k;
        int            rc;
        w  = req_wr;
        a  = req_addr;
        d  = req_data;
        b  = req_be;
        rc = w ? 5 : 6;
        check("ready_cycle0", {31'd0, req_ready}, 32'd1);
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        req_data = $urandom;
        req_be   = 4'($urandom);
        if (hold) begin
            req_wr   = nwr;
            req_addr = naddr;
        end else begin
            req_valid = 1'b0;
            req_wr    = 1'($urandom);
            req_addr  = AW'($urandom);
        end
        for (int cyc = 1; cyc <= rc + 1; cyc++) begin
            @(negedge clock);
            if (cyc <= 4) begin
                k = 2'(cyc - 1);
                check("mem_address", {19'd0, mem_address}, {19'd0, a[AW-1:2], k});
                check("mem_wren", {31'd0, mem_wren}, {31'd0, w && b[k]});
                check("mem_rden", {31'd0, mem_rden}, {31'd0, !w});
                check("mem_data", {24'd0, mem_data}, w ? {24'd0, d[{k, 3'b000} +: 8]} : 32'd0);
            end else begin
                check("mem_quiet", {mem_wren, mem_rden, mem_data, 9'd0, mem_address}, 32'd0);
            end
            check("req_ready", {31'd0, req_ready}, {31'd0, cyc == rc + 1});
            check("rsp_valid", {31'd0, rsp_valid}, {31'd0, cyc == rc});
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $error("FAIL sb_unexpected_rsp: observed %h expected none", rsp_data);
                end else begin
                    check("rsp_data", rsp_data, exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_be    = '0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_mem", {mem_wren, mem_rden, mem_data, 9'd0, mem_address}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("idle_quiet", {29'd0, rsp_valid, mem_wren, mem_rden}, 32'd0);
            check("idle_ready", {31'd0, req_ready}, 32'd1);
        end

        // Full write then read back from a misaligned address of the same word
        drive(1'b1, 13'h0010, 32'hDEADBEEF, 4'hF);
        xfer(32'h0, 1'b0, 1'b0, '0);
        drive(1'b0, 13'h0012, 32'h0, 4'h0);
        xfer(32'hDEADBEEF, 1'b0, 1'b0, '0);

        // Partial byte enables
        drive(1'b1, 13'h0010, 32'h11223344, 4'h5);
        xfer(32'h0, 1'b0, 1'b0, '0);
        drive(1'b0, 13'h0010, 32'h0, 4'h0);
        xfer(32'hDE22BE44, 1'b0, 1'b0, '0);

        // Top word, written via an unaligned byte address
        drive(1'b1, 13'h1FFF, 32'h01020304, 4'hF);
        xfer(32'h0, 1'b0, 1'b0, '0);

        // Zero byte enables: four silent cycles, still acknowledged
        drive(1'b1, 13'h0010, 32'h55555555, 4'h0);
        xfer(32'h0, 1'b0, 1'b0, '0);

        // Back-to-back reads with req_valid held high
        drive(1'b0, 13'h0010, 32'h0, 4'h0);
        xfer(32'hDE22BE44, 1'b1, 1'b0, 13'h1FFC);
        xfer(32'h01020304, 1'b0, 1'b0, '0);
        check("no_wrap_mem0", {24'd0, mem[0]}, 32'd0);

        // Reset during the third byte of a write over zeroed data
        drive(1'b1, 13'h0020, 32'h0, 4'hF);
        xfer(32'h0, 1'b0, 1'b0, '0);
        drive(1'b1, 13'h0020, 32'hAABBCCDD, 4'hF);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_addr", {19'd0, mem_address}, 32'h22);
        check("abort_wren", {31'd0, mem_wren}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort_quiet", {29'd0, rsp_valid, mem_wren, mem_rden}, 32'd0);
        check("abort_idle", {31'd0, req_ready}, 32'd1);
        #1 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clock);
            check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        drive(1'b0, 13'h0020, 32'h0, 4'h0);
        xfer(32'h0000CCDD, 1'b0, 1'b0, '0);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
